// File: rtl/id_confirm_if.sv
// ============================================================================
// Module  : id_confirm_if
// Brief   : Raw classifier sample in, confirmed id out.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface id_confirm_if;
    logic [2:0] raw_id;
    logic       raw_valid;
    logic [2:0] id;
    logic       id_valid;
    logic       id_locked;
    logic       alarm;

    modport master (
        output raw_id, raw_valid,
        input  id, id_valid, id_locked, alarm
    );

    modport slave (
        input  raw_id, raw_valid,
        output id, id_valid, id_locked, alarm
    );
endinterface

`default_nettype wire

// File: rtl/id_confirm_filter.sv
// ============================================================================
// Module  : id_confirm_filter
// Brief   : Confirms a raw 3-bit identity over consecutive samples and holds it.
//           Optional impersonation alarm built when ID_MISMATCH_ALARM_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_confirm_filter #(
    parameter int CONFIRM_COUNT = 3,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int HOLD_W        = 26,
    parameter int ALARM_COUNT   = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    id_confirm_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]        c_CONFIRM   = 4'(CONFIRM_COUNT);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    function automatic logic is_known(input logic [2:0] code);
        case (code)
            3'b001, 3'b010, 3'b011, 3'b101, 3'b110: is_known = 1'b1;
            default:                                is_known = 1'b0;
        endcase
    endfunction

    state_t            r_state, w_state;
    logic [2:0]        r_cand, w_cand;
    logic [3:0]        r_streak, w_streak;
    logic [HOLD_W-1:0] r_hold, w_hold;
    logic [2:0]        r_id, w_id;
    logic              r_id_valid, w_id_valid;
    logic              r_locked, w_locked;
    logic              w_known;
    logic              w_enter;
    logic              w_release;

    assign w_known = is_known(bus.raw_id);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cand     <= 3'b000;
            r_streak   <= 4'd0;
            r_hold     <= '0;
            r_id       <= 3'b000;
            r_id_valid <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cand     <= w_cand;
            r_streak   <= w_streak;
            r_hold     <= w_hold;
            r_id       <= w_id;
            r_id_valid <= w_id_valid;
            r_locked   <= w_locked;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cand     = r_cand;
        w_streak   = r_streak;
        w_hold     = r_hold;
        w_id       = r_id;
        w_id_valid = 1'b0;
        w_locked   = r_locked;
        w_enter    = 1'b0;
        w_release  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.raw_valid && w_known) begin
                    w_cand   = bus.raw_id;
                    w_streak = 4'd1;
                    if (c_CONFIRM <= 4'd1) w_enter = 1'b1;
                    else                   w_state = S_TRACK;
                end
            end
            S_TRACK: begin
                if (bus.raw_valid) begin
                    if (bus.raw_id == r_cand) begin
                        if (r_streak + 4'd1 >= c_CONFIRM) begin
                            w_streak = c_CONFIRM;
                            w_enter  = 1'b1;
                        end else begin
                            w_streak = r_streak + 4'd1;
                        end
                    end else if (w_known) begin
                        w_cand   = bus.raw_id;
                        w_streak = 4'd1;
                    end else begin
                        w_state  = S_IDLE;
                        w_streak = 4'd0;
                    end
                end
            end
            S_LOCKED: begin
                // Samples are ignored here; only the hold timer drives the exit.
                if (r_hold == c_HOLD_LAST) w_release = 1'b1;
                else                       w_hold    = r_hold + 1'b1;
            end
            default: w_state = S_IDLE;
        endcase

        if (w_enter) begin
            w_state    = S_LOCKED;
            w_id       = w_cand;
            w_id_valid = 1'b1;
            w_locked   = 1'b1;
            w_hold     = '0;
        end
        if (w_release) begin
            w_state  = S_IDLE;
            w_id     = 3'b000;
            w_locked = 1'b0;
            w_hold   = '0;
            w_streak = 4'd0;
        end
    end

    assign bus.id        = r_id;
    assign bus.id_valid  = r_id_valid;
    assign bus.id_locked = r_locked;

`ifdef ID_MISMATCH_ALARM_EN
    localparam logic [3:0] c_ALARM_LIM = 4'(ALARM_COUNT);

    logic [3:0] r_mism, w_mism;
    logic       r_alarm, w_alarm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mism  <= 4'd0;
            r_alarm <= 1'b0;
        end else begin
            r_mism  <= w_mism;
            r_alarm <= w_alarm;
        end
    end

    always_comb begin
        w_mism  = r_mism;
        w_alarm = r_alarm;
        if (w_enter || w_release) begin
            w_mism  = 4'd0;
            w_alarm = 1'b0;
        end else if (r_state == S_LOCKED && bus.raw_valid && w_known && bus.raw_id != r_id) begin
            if (r_mism < c_ALARM_LIM) w_mism = r_mism + 4'd1;
            if (w_mism >= c_ALARM_LIM) w_alarm = 1'b1;
        end
    end

    assign bus.alarm = r_alarm;
`else
    assign bus.alarm = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_confirm_filter.sv
// ============================================================================
// Module  : tb_id_confirm_filter
// Brief   : Scoreboard bench for id_confirm_filter (CONFIRM=3/HOLD=20 and CONFIRM=1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_confirm_filter;

`ifdef ID_MISMATCH_ALARM_EN
    localparam logic EXP_ALARM = 1'b1;
`else
    localparam logic EXP_ALARM = 1'b0;
`endif

    typedef struct {
        logic [2:0] id;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q0[$];
    exp_t q1[$];

    id_confirm_if bus0 ();
    id_confirm_if bus1 ();

    id_confirm_filter #(
        .CONFIRM_COUNT(3), .HOLD_CYCLES(20), .HOLD_W(5), .ALARM_COUNT(2)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    id_confirm_filter #(
        .CONFIRM_COUNT(1), .HOLD_CYCLES(4), .HOLD_W(2), .ALARM_COUNT(2)
    ) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Each id_valid pulse must match the oldest expected lock, id and cycle.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst && bus0.id_valid === 1'b1) begin
            if (q0.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse0: id %0h, no pulse expected", bus0.id);
            end else begin
                e = q0.pop_front();
                chk("lock_id0", 32'(bus0.id), 32'(e.id));
                chk("lock_cycle0", cyc, e.cyc);
                chk("locked_flag0", 32'(bus0.id_locked), 32'd1);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && bus1.id_valid === 1'b1) begin
            if (q1.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse1: id %0h, no pulse expected", bus1.id);
            end else begin
                e = q1.pop_front();
                chk("lock_id1", 32'(bus1.id), 32'(e.id));
                chk("lock_cycle1", cyc, e.cyc);
            end
        end
    end

    task automatic send0(input logic [2:0] code, input logic v, input bit push);
        exp_t e;
        @(negedge clk);
        bus0.raw_id    = code;
        bus0.raw_valid = v;
        if (push) begin
            e.id  = code;
            e.cyc = cyc + 1;
            q0.push_back(e);
        end
    endtask

    task automatic idle0();
        @(negedge clk);
        bus0.raw_valid = 1'b0;
        bus0.raw_id    = 3'b000;
    endtask

    task automatic wait_unlocked0();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!bus0.id_locked) done = 1'b1;
        end
        chk("release_timeout", 32'(done), 32'd1);
    endtask

    initial begin : stim
        int  n;
        bit  done;
        exp_t e;
        bus0.raw_id = 3'b000; bus0.raw_valid = 1'b0;
        bus1.raw_id = 3'b000; bus1.raw_valid = 1'b0;

        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_id", 32'(bus0.id), 32'd0);
        chk("rst_id_valid", 32'(bus0.id_valid), 32'd0);
        chk("rst_locked", 32'(bus0.id_locked), 32'd0);
        chk("rst_alarm", 32'(bus0.alarm), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic lock and hold length
        send0(3'b010, 1, 0); send0(3'b010, 1, 0); send0(3'b010, 1, 1);
        n = 0; done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus0.raw_valid = 1'b0;
            if (bus0.id_locked) n++;
            else begin done = 1'b1; break; end
        end
        chk("hold_len", n, 20);
        chk("hold_done", 32'(done), 32'd1);
        chk("release_id", 32'(bus0.id), 32'd0);

        // Restart on new known code
        send0(3'b010, 1, 0); send0(3'b010, 1, 0);
        send0(3'b101, 1, 0); send0(3'b101, 1, 0); send0(3'b101, 1, 1);
        idle0();
        wait_unlocked0();

        // Unknown code drops back to IDLE
        send0(3'b011, 1, 0); send0(3'b011, 1, 0); send0(3'b111, 1, 0);
        send0(3'b011, 1, 0); send0(3'b011, 1, 0); send0(3'b011, 1, 1);
        idle0();
        wait_unlocked0();

        // Unknown codes never leave IDLE
        send0(3'b000, 1, 0); send0(3'b100, 1, 0); send0(3'b111, 1, 0);
        idle0();
        repeat (3) @(negedge clk);
        chk("unknown_no_lock", 32'(bus0.id_locked), 32'd0);

        // Gaps in raw_valid keep the streak
        send0(3'b101, 1, 0); send0(3'b101, 0, 0); send0(3'b110, 0, 0);
        send0(3'b101, 1, 0); send0(3'b101, 0, 0); send0(3'b101, 1, 1);
        idle0();
        wait_unlocked0();

        // Asynchronous reset mid-lock
        send0(3'b110, 1, 0); send0(3'b110, 1, 0); send0(3'b110, 1, 1);
        idle0();
        repeat (3) @(negedge clk);
        chk("pre_rst_locked", 32'(bus0.id_locked), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_id", 32'(bus0.id), 32'd0);
        chk("async_rst_locked", 32'(bus0.id_locked), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("post_rst_locked", 32'(bus0.id_locked), 32'd0);

        // Mismatching samples while locked
        send0(3'b001, 1, 0); send0(3'b001, 1, 0); send0(3'b001, 1, 1);
        send0(3'b110, 1, 0); send0(3'b000, 1, 0); send0(3'b110, 1, 0);
        idle0();
        chk("alarm_level", 32'(bus0.alarm), 32'(EXP_ALARM));
        chk("id_held", 32'(bus0.id), 32'd1);
        wait_unlocked0();
        chk("alarm_cleared", 32'(bus0.alarm), 32'd0);

        // CONFIRM_COUNT=1 instance
        @(negedge clk);
        bus1.raw_id = 3'b001; bus1.raw_valid = 1'b1;
        e.id = 3'b001; e.cyc = cyc + 1;
        q1.push_back(e);
        @(negedge clk);
        bus1.raw_valid = 1'b0; bus1.raw_id = 3'b000;
        repeat (8) @(negedge clk);
        chk("dut1_released", 32'(bus1.id_locked), 32'd0);

        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
